// File: rtl/cpu_axi_bridge_mc_if.sv
// AXI3 channel bundle between cpu_axi_bridge_mc (master) and the downstream slave.
interface cpu_axi_bridge_mc_if #(
    parameter int unsigned ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge_mc.sv
// Multi-port SRAM-like to AXI3 bridge: round-robin arbitration, one transaction in flight,
// read bursts up to MAX_LEN beats and single-beat writes.
module cpu_axi_bridge_mc #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MAX_LEN   = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_PORTS-1:0]      req,
    input  logic [NUM_PORTS-1:0]      wr,
    input  logic [2*NUM_PORTS-1:0]    size,
    input  logic [4*NUM_PORTS-1:0]    len,
    input  logic [32*NUM_PORTS-1:0]   addr,
    input  logic [32*NUM_PORTS-1:0]   wdata,
    output logic [NUM_PORTS-1:0]      addr_ok,
    output logic [NUM_PORTS-1:0]      data_ok,
    output logic [31:0]               rdata_o,
    cpu_axi_bridge_mc_if.master       axi
);
    localparam int unsigned PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0]  LEN_MAX = 4'(MAX_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] port_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic [3:0]    len_q;
    logic [3:0]    strb_q;
    logic          arvalid_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          rready_q;
    logic          bready_q;

    logic          gnt_vld;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] gnt_next;
    logic [31:0]   scan_idx;
    logic          sel_wr;
    logic [1:0]    sel_size;
    logic [3:0]    sel_len;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_strb;

    // First requesting port found scanning upward from rr_ptr.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = (32'(rr_ptr) + i) % NUM_PORTS;
            if (!gnt_vld && req[PW'(scan_idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(scan_idx);
            end
        end
    end

    assign gnt_next  = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PW'(1);
    assign sel_wr    = wr[gnt_idx];
    assign sel_size  = size[32'(gnt_idx)*2 +: 2];
    assign sel_len   = len[32'(gnt_idx)*4 +: 4];
    assign sel_addr  = addr[32'(gnt_idx)*32 +: 32];
    assign sel_wdata = wdata[32'(gnt_idx)*32 +: 32];

    always_comb begin
        case (sel_size)
            2'd0:    sel_strb = 4'b0001 << sel_addr[1:0];
            2'd1:    sel_strb = 4'b0011 << sel_addr[1:0];
            default: sel_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            port_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            len_q     <= '0;
            strb_q    <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            addr_ok   <= '0;
        end else begin
            addr_ok <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        addr_ok <= NUM_PORTS'(1) << gnt_idx;
                        rr_ptr  <= gnt_next;
                        port_q  <= gnt_idx;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        size_q  <= sel_size;
                        len_q   <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
                        strb_q  <= sel_strb;
                        if (sel_wr) begin
                            state     <= WR_ADDR_DATA;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arvalid_q && axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.rvalid && axi.rlast) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently; leave once neither is outstanding.
                    if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulses follow the slave's beat directly; masked while reset is applied.
    always_comb begin
        data_ok = '0;
        if (!areset && ((rready_q && axi.rvalid) || (bready_q && axi.bvalid)))
            data_ok[port_q] = 1'b1;
    end

    assign rdata_o = axi.rdata;

    assign axi.arid    = ID_W'(port_q);
    assign axi.araddr  = addr_q;
    assign axi.arlen   = {4'b0000, len_q};
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = ID_W'(port_q);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awvalid = awvalid_q;

    assign axi.wid     = ID_W'(port_q);
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Response codes and IDs returned by the slave carry no information for this bridge.
    logic unused_axi;
    assign unused_axi = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};
endmodule

// File: tb/tb_cpu_axi_bridge_mc.sv
// Randomized bench for cpu_axi_bridge_mc: the bench acts as AXI slave and requesters,
// predicting grants, AXI fields and completion pulses from a behavioural model.
module tb_cpu_axi_bridge_mc;
    localparam int unsigned NP      = 2;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned MAX_LEN = 8;

    logic              aclk;
    logic              areset;
    logic [NP-1:0]     req;
    logic [NP-1:0]     wr;
    logic [2*NP-1:0]   size;
    logic [4*NP-1:0]   len;
    logic [32*NP-1:0]  addr;
    logic [32*NP-1:0]  wdata;
    logic [NP-1:0]     addr_ok;
    logic [NP-1:0]     data_ok;
    logic [31:0]       rdata_o;

    cpu_axi_bridge_mc_if #(.ID_W(ID_W)) axi();

    cpu_axi_bridge_mc #(.NUM_PORTS(NP), .ID_W(ID_W), .MAX_LEN(MAX_LEN)) dut (
        .aclk(aclk), .areset(areset), .req(req), .wr(wr), .size(size), .len(len),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata_o(rdata_o), .axi(axi)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int ref_rr   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Outside IDLE no port may be granted.
    task automatic step_busy();
        step();
        check("no_grant_busy", 64'(addr_ok), 64'd0);
    endtask

    task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic [3:0] ln,
                            input logic [31:0] a, input logic [31:0] d);
        req[p]         = 1'b1;
        wr[p]          = w;
        size[p*2 +: 2] = sz;
        len[p*4 +: 4]  = ln;
        addr[p*32 +: 32]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic rand_port(input int p);
        set_port(p, 1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), 4'($urandom_range(15, 0)),
                 $urandom, $urandom);
    endtask

    // Byte lanes covered by an access of 1, 2 or 4 bytes starting at the address' byte offset.
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        int lo;
        logic [3:0] s;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lo = (sz == 2'd2) ? 0 : int'(a[1:0]);
        s  = '0;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + nb) s[b] = 1'b1;
        return s;
    endfunction

    // One full transaction: predicts the grant, then plays the slave with the given delays.
    task automatic do_txn(input int ar_d, input int aw_d, input int w_d, input int b_d,
                          input int gap_max, output int g);
        int          ge;
        logic        e_wr;
        logic [1:0]  e_sz;
        logic [3:0]  e_len;
        logic [31:0] e_a;
        logic [31:0] e_d;
        logic [31:0] beat;
        int          exp_len;
        int          n;
        ge = -1;
        for (int i = 0; i < NP; i++)
            if (ge < 0 && req[(ref_rr + i) % NP]) ge = (ref_rr + i) % NP;
        if (ge < 0) begin
            $display("FAIL stimulus: no requester asserted before transaction");
            $fatal(1, "bench stimulus error");
        end
        e_wr  = wr[ge];
        e_sz  = size[ge*2 +: 2];
        e_len = len[ge*4 +: 4];
        e_a   = addr[ge*32 +: 32];
        e_d   = wdata[ge*32 +: 32];
        exp_len = (int'(e_len) > MAX_LEN - 1) ? MAX_LEN - 1 : int'(e_len);

        step();
        check("grant", 64'(addr_ok), 64'(1) << ge);
        req[ge] = 1'b0;
        ref_rr  = (ge + 1) % NP;
        g       = ge;

        if (!e_wr) begin
            check("arvalid", 64'(axi.arvalid), 64'd1);
            check("arid", 64'(axi.arid), 64'(ge));
            check("araddr", 64'(axi.araddr), 64'(e_a));
            check("arlen", 64'(axi.arlen), 64'(exp_len));
            check("arsize", 64'(axi.arsize), 64'(e_sz));
            check("arburst", 64'(axi.arburst), 64'd1);
            check("ar_attr", 64'({axi.arlock, axi.arcache, axi.arprot}), 64'd0);
            for (int d = 0; d < ar_d; d++) begin
                axi.arready = 1'b0;
                step_busy();
                check("ar_hold", 64'(axi.arvalid), 64'd1);
            end
            axi.arready = 1'b1;
            step_busy();
            axi.arready = 1'b0;
            check("ar_done", 64'(axi.arvalid), 64'd0);
            check("rready_on", 64'(axi.rready), 64'd1);
            for (int b = 0; b <= exp_len; b++) begin
                n = $urandom_range(gap_max, 0);
                for (int k = 0; k < n; k++) begin
                    axi.rvalid = 1'b0;
                    #2;
                    check("r_gap", 64'(data_ok), 64'd0);
                    step_busy();
                end
                beat        = $urandom;
                axi.rvalid  = 1'b1;
                axi.rdata   = beat;
                axi.rlast   = (b == exp_len);
                axi.rresp   = 2'($urandom_range(3, 0));
                axi.rid     = ID_W'(ge);
                #2;
                check("r_data_ok", 64'(data_ok), 64'(1) << ge);
                check("rdata_o", 64'(rdata_o), 64'(beat));
                step_busy();
            end
            axi.rlast = 1'b0;
            #2;
            check("r_after_last", 64'(data_ok), 64'd0);
            check("rready_off", 64'(axi.rready), 64'd0);
            axi.rvalid = 1'b0;
        end else begin
            check("awvalid", 64'(axi.awvalid), 64'd1);
            check("wvalid", 64'(axi.wvalid), 64'd1);
            check("awid", 64'(axi.awid), 64'(ge));
            check("wid", 64'(axi.wid), 64'(ge));
            check("awaddr", 64'(axi.awaddr), 64'(e_a));
            check("awlen", 64'(axi.awlen), 64'd0);
            check("awsize", 64'(axi.awsize), 64'(e_sz));
            check("awburst", 64'(axi.awburst), 64'd1);
            check("aw_attr", 64'({axi.awlock, axi.awcache, axi.awprot}), 64'd0);
            check("wstrb", 64'(axi.wstrb), 64'(exp_strb(e_sz, e_a)));
            check("wdata", 64'(axi.wdata), 64'(e_d));
            check("wlast", 64'(axi.wlast), 64'd1);
            n = (aw_d > w_d) ? aw_d : w_d;
            for (int c = 0; c <= n; c++) begin
                axi.awready = (c >= aw_d);
                axi.wready  = (c >= w_d);
                step_busy();
                if (c < n) begin
                    check("aw_pending", 64'(axi.awvalid), 64'(c < aw_d));
                    check("w_pending", 64'(axi.wvalid), 64'(c < w_d));
                    check("bready_early", 64'(axi.bready), 64'd0);
                end
            end
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            check("aw_done", 64'(axi.awvalid), 64'd0);
            check("w_done", 64'(axi.wvalid), 64'd0);
            check("bready_on", 64'(axi.bready), 64'd1);
            for (int d = 0; d < b_d; d++) begin
                axi.bvalid = 1'b0;
                #2;
                check("b_wait", 64'(data_ok), 64'd0);
                step_busy();
            end
            axi.bvalid = 1'b1;
            axi.bresp  = 2'($urandom_range(3, 0));
            axi.bid    = ID_W'(ge);
            #2;
            check("b_data_ok", 64'(data_ok), 64'(1) << ge);
            step_busy();
            #2;
            check("b_once", 64'(data_ok), 64'd0);
            check("bready_off", 64'(axi.bready), 64'd0);
            axi.bvalid = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int other;
        areset = 1'b1;
        req = '0; wr = '0; size = '0; len = '0; addr = '0; wdata = '0;
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rid = '0;
        axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
        repeat (3) step();
        check("rst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), 64'd0);
        check("rst_addr_ok", 64'(addr_ok), 64'd0);
        check("rst_data_ok", 64'(data_ok), 64'd0);
        areset = 1'b0;

        // Both ports request continuously from the first cycle after release.
        rand_port(0);
        rand_port(1);
        for (int t = 0; t < 4; t++) begin
            do_txn(1, 1, 0, 1, 1, g);
            check("alternate", 64'(g), 64'(t % 2));
            rand_port(g);
        end
        req = '0;

        set_port(0, 1'b0, 2'd2, 4'd0, 32'h1FC0_0000, 32'h0);
        do_txn(2, 0, 0, 0, 0, g);

        set_port(1, 1'b1, 2'd0, 4'd5, 32'h8000_0003, 32'hAB00_0000);
        do_txn(0, 3, 0, 2, 0, g);
        check("byte_wr_port", 64'(g), 64'd1);

        set_port(0, 1'b0, 2'd2, 4'd3, $urandom, 32'h0);
        do_txn(1, 0, 0, 0, 3, g);
        set_port(1, 1'b0, 2'd2, 4'd15, $urandom, 32'h0);
        do_txn(0, 0, 0, 0, 2, g);

        set_port(0, 1'b1, 2'd1, 4'd0, 32'h1000_0002, $urandom);
        do_txn(0, 0, 0, 1, 0, g);
        set_port(1, 1'b1, 2'd2, 4'd0, $urandom, $urandom);
        do_txn(0, 2, 2, 0, 0, g);

        // Reset in the middle of a 4-beat read, after the first beat.
        req = '0;
        g = ref_rr;
        other = (g + 1) % NP;
        set_port(g, 1'b0, 2'd2, 4'd3, $urandom, 32'h0);
        step();
        check("mid_rst_grant", 64'(addr_ok), 64'(1) << g);
        req[g] = 1'b0;
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        check("mid_rst_rready", 64'(axi.rready), 64'd1);
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b0;
        axi.rdata  = 32'h1234_5678;
        #2;
        check("mid_rst_beat1", 64'(data_ok), 64'(1) << g);
        step();
        areset = 1'b1;
        set_port(other, 1'b0, 2'd2, 4'd0, $urandom, 32'h0);
        #2;
        check("mid_rst_no_ok", 64'(data_ok), 64'd0);
        step();
        check("mid_rst_valids", 64'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), 64'd0);
        check("mid_rst_addr_ok", 64'(addr_ok), 64'd0);
        #2;
        check("mid_rst_data_ok", 64'(data_ok), 64'd0);
        areset = 1'b0;
        axi.rvalid = 1'b0;
        ref_rr = 0;
        do_txn(0, 0, 0, 0, 1, g);
        check("post_rst_port", 64'(g), 64'(other));

        for (int t = 0; t < 150; t++) begin
            req = '0;
            for (int p = 0; p < NP; p++) if ($urandom_range(1, 0) == 1) rand_port(p);
            if (req == '0) rand_port(int'($urandom_range(NP - 1, 0)));
            do_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), 3, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
